// File: rtl/axi_tx_flit_fifo.sv
// Elastic first-word-fall-through FIFO feeding the AXI-stream tx channel.
// Status outputs are registered from the next-state occupancy, so no output depends combinationally on the handshake inputs.
module axi_tx_flit_fifo #(
    parameter int T_DATA_BIT   = 128,
    parameter int T_USER_WIDTH = 16,
    parameter int DEPTH        = 16,
    parameter int AF_THRESH    = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [T_DATA_BIT-1:0]      in_data,
    input  logic [T_USER_WIDTH-1:0]    in_user,
    output logic                       t_valid,
    input  logic                       t_ready,
    output logic [T_DATA_BIT-1:0]      t_data,
    output logic [T_USER_WIDTH-1:0]    t_user,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BEAT_W = T_DATA_BIT + T_USER_WIDTH;

    logic [BEAT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             t_valid_q, t_valid_d;
    logic             almost_full_q, almost_full_d;
    logic             push_s, pop_s;

    // Handshakes only use registered status, so full never passes a beat through combinationally.
    always_comb begin
        push_s        = in_valid & in_ready_q;
        pop_s         = t_valid_q & t_ready;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        in_ready_d    = (count_d != CNT_W'(DEPTH));
        t_valid_d     = (count_d != {CNT_W{1'b0}});
        almost_full_d = (count_d >= CNT_W'(AF_THRESH));
    end

    // Pointer, occupancy and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            in_ready_q    <= 1'b0;
            t_valid_q     <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            t_valid_q     <= t_valid_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Beat storage is deliberately left unreset; a flushed write is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_s) begin
            mem[wr_ptr_q] <= {in_data, in_user};
        end
    end

    assign {t_data, t_user} = mem[rd_ptr_q];
    assign in_ready         = in_ready_q;
    assign t_valid          = t_valid_q;
    assign count            = count_q;
    assign almost_full      = almost_full_q;

endmodule

// File: tb/tb_axi_tx_flit_fifo.sv
// Self-checking bench for axi_tx_flit_fifo: directed vector table, hand sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_axi_tx_flit_fifo;

    localparam int DW = 128;
    localparam int UW = 16;
    localparam int D  = 16;
    localparam int AF = 12;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, t_valid, t_ready, almost_full;
    logic [DW-1:0] in_data, t_data;
    logic [UW-1:0] in_user, t_user;
    logic [4:0]    count;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_push = 0;

    logic [DW+UW-1:0] q [$];
    bit               ready_m;

    typedef struct {
        logic          r, f, iv, tr;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        int            exp_count;
        logic          exp_tv, exp_ir, exp_af;
    } vec_t;
    vec_t tbl [5];

    axi_tx_flit_fifo #(.T_DATA_BIT(DW), .T_USER_WIDTH(UW), .DEPTH(D), .AF_THRESH(AF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_user(in_user),
        .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data), .t_user(t_user),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW+UW-1:0] act, input logic [DW+UW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model follows the FIFO rules with a plain queue.
    task automatic cycle(input logic r, input logic f, input logic iv, input logic tr,
                         input logic [DW-1:0] d, input logic [UW-1:0] u);
        bit push, pop;
        rst_n = r; flush = f; in_valid = iv; t_ready = tr; in_data = d; in_user = u;
        push = iv && ready_m && (q.size() != D);
        pop  = tr && (q.size() != 0);
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            ready_m = 1'b0;
        end else if (f) begin
            q.delete();
            ready_m = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({d, u});
                n_push++;
            end
            ready_m = 1'b1;
        end
        chk("count", (DW+UW)'(count), (DW+UW)'(q.size()));
        chk("t_valid", (DW+UW)'(t_valid), (DW+UW)'(q.size() != 0));
        chk("in_ready", (DW+UW)'(in_ready), (DW+UW)'(ready_m && q.size() != D));
        chk("almost_full", (DW+UW)'(almost_full), (DW+UW)'(q.size() >= AF));
        if (q.size() != 0) chk("head_beat", {t_data, t_user}, q[0]);
    endtask

    initial begin
        ready_m = 1'b0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; t_ready = 1'b0;
        in_data = '0; in_user = '0;

        // Reset, release, single beat through an empty FIFO.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 16'h0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 128'h0, 16'h0, 0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 16'h0, 0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 128'hA5A5_0001, 16'h0003, 1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 128'h0, 16'h0, 0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].tr, tbl[i].d, tbl[i].u);
            chk("tbl_count", (DW+UW)'(count), (DW+UW)'(tbl[i].exp_count));
            chk("tbl_t_valid", (DW+UW)'(t_valid), (DW+UW)'(tbl[i].exp_tv));
            chk("tbl_in_ready", (DW+UW)'(in_ready), (DW+UW)'(tbl[i].exp_ir));
            chk("tbl_almost_full", (DW+UW)'(almost_full), (DW+UW)'(tbl[i].exp_af));
            if (i == 3) chk("tbl_first_beat", {t_data, t_user}, {128'hA5A5_0001, 16'h0003});
        end

        // Fill to full with the sink stalled, offer a 17th beat, then drain.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, DW'(i), UW'(i));
            if (i == 10) chk("af_before_12", (DW+UW)'(almost_full), (DW+UW)'(1'b0));
            if (i == 11) chk("af_at_12", (DW+UW)'(almost_full), (DW+UW)'(1'b1));
        end
        chk("full_in_ready", (DW+UW)'(in_ready), (DW+UW)'(1'b0));
        chk("full_count", (DW+UW)'(count), (DW+UW)'(16));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 128'd99, 16'd99);
        chk("held_17th_count", (DW+UW)'(count), (DW+UW)'(16));
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", (DW+UW)'(t_data), (DW+UW)'(i));
            cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
            if (i == 0) chk("ready_after_pop", (DW+UW)'(in_ready), (DW+UW)'(1'b1));
        end

        // Full FIFO under continuous push and pop: pointers wrap several times.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom), UW'($urandom));
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("wrap_drained", (DW+UW)'(t_valid), (DW+UW)'(1'b0));

        // Flush at count 5 with a concurrent push and pop.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, DW'(100 + i), '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 128'hDEAD, 16'hBEEF);
        chk("flush_count", (DW+UW)'(count), (DW+UW)'(0));
        chk("flush_t_valid", (DW+UW)'(t_valid), (DW+UW)'(1'b0));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 128'h77, 16'h7);
        chk("post_flush_head", {t_data, t_user}, {128'h77, 16'h7});
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);

        // Random traffic, then reset mid-stream.
        n_push = 0;
        for (int c = 0; c < 6000 && n_push < 1000; c++)
            cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        chk("rand_budget", (DW+UW)'(n_push >= 1000), (DW+UW)'(1'b1));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("reset_t_valid", (DW+UW)'(t_valid), (DW+UW)'(1'b0));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
            chk("no_stale_beat", (DW+UW)'(t_valid), (DW+UW)'(1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
